// File: rtl/call_stack_pkg.sv
// call_stack_pkg: shared FSM state encoding and default sizing for the call-stack controller.
package call_stack_pkg;
    localparam int CS_PC_WIDTH = 5;
    localparam int CS_DEPTH = 15;
    typedef enum logic [2:0] {IDLE, PUSH, POP_RD, POP, DONE} state_t;
endpackage

// File: rtl/ret_pc_lifo.sv
// ret_pc_lifo: return-PC storage, entries 1..D, synchronous write and combinational read, never reset.
module ret_pc_lifo #(
    parameter int W = 5,
    parameter int D = 15
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic [W-1:0] raddr,
    output logic [W-1:0] rdata
);
    logic [W-1:0] mem [1:D];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl: CALL/RET sequencer driving PC load and register-file frame save/restore strobes.
module call_stack_ctrl
    import call_stack_pkg::*;
#(
    parameter int PC_WIDTH = CS_PC_WIDTH,
    parameter int DEPTH = CS_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cs_call,
    input  logic                cs_ret,
    input  logic [PC_WIDTH-1:0] cs_target_pc,
    input  logic [PC_WIDTH-1:0] cs_pc_cur,
    input  logic                cs_clr_err,
    output logic                cs_busy,
    output logic                cs_done,
    output logic                cs_pc_load,
    output logic [PC_WIDTH-1:0] cs_pc_next,
    output logic                rf_stack_push,
    output logic                rf_stack_pop,
    output logic [PC_WIDTH-1:0] rf_stack_pointer,
    output logic [PC_WIDTH-1:0] cs_depth,
    output logic                cs_overflow,
    output logic                cs_underflow
);
    localparam logic [PC_WIDTH-1:0] FULL = PC_WIDTH'(DEPTH);
    state_t state, state_nx;
    logic [PC_WIDTH-1:0] sp, pc_q, lifo_rd;
    logic call_ok, ret_ok, ovf_set, unf_set;
    // CALL has priority, so a RET only counts when CALL is low
    assign call_ok = state == IDLE && cs_call && sp != FULL;
    assign ovf_set = state == IDLE && cs_call && sp == FULL;
    assign ret_ok  = state == IDLE && !cs_call && cs_ret && sp != '0;
    assign unf_set = state == IDLE && !cs_call && cs_ret && sp == '0;
    assign cs_pc_next = pc_q;
    assign cs_depth = sp;
    always_comb begin
        state_nx = IDLE;
        cs_busy = state != IDLE;
        cs_done = state == DONE;
        cs_pc_load = state == DONE;
        rf_stack_push = state == PUSH;
        rf_stack_pop = state == POP;
        rf_stack_pointer = state == PUSH ? sp + 1'b1 : sp;
        state_nx = state == IDLE ? (call_ok ? PUSH : ret_ok ? POP_RD : IDLE) :
                   state == POP_RD ? POP :
                   state == PUSH || state == POP ? DONE : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            sp <= '0;
            pc_q <= '0;
            cs_overflow <= 1'b0;
            cs_underflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (call_ok) pc_q <= cs_target_pc;
            else if (state == POP) pc_q <= lifo_rd;
            if (state == PUSH) sp <= sp + 1'b1;
            else if (state == POP) sp <= sp - 1'b1;
            cs_overflow <= (cs_overflow && !cs_clr_err) || ovf_set;
            cs_underflow <= (cs_underflow && !cs_clr_err) || unf_set;
        end
    ret_pc_lifo #(.W(PC_WIDTH), .D(DEPTH)) u_lifo (
        .clk(clk),
        .we(state == PUSH),
        .waddr(rf_stack_pointer),
        .wdata(cs_pc_cur + 1'b1),
        .raddr(sp),
        .rdata(lifo_rd)
    );
endmodule

// File: tb/tb_call_stack_ctrl.sv
// tb_call_stack_ctrl: scoreboard bench for call_stack_ctrl; per-cycle control checks plus queued PC/depth results.
module tb_call_stack_ctrl;
    localparam int W = 5;
    localparam int D = 15;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cs_call = 1'b0, cs_ret = 1'b0, cs_clr_err = 1'b0;
    logic [W-1:0] cs_target_pc = '0, cs_pc_cur = '0;
    logic cs_busy, cs_done, cs_pc_load, rf_stack_push, rf_stack_pop, cs_overflow, cs_underflow;
    logic [W-1:0] cs_pc_next, rf_stack_pointer, cs_depth;
    typedef struct packed {logic [W-1:0] pc; logic [W-1:0] depth;} exp_t;
    exp_t sb[$];
    exp_t e;
    int vectors = 0;
    int miscompares = 0;
    int m_sp = 0;
    logic [W-1:0] m_lifo [0:D];
    logic [4+2*W:0] ctl;
    // {busy, done, pc_load, push, pop, pointer, depth}
    assign ctl = {cs_busy, cs_done, cs_pc_load, rf_stack_push, rf_stack_pop, rf_stack_pointer, cs_depth};

    always #5 clk = ~clk;

    call_stack_ctrl #(.PC_WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .cs_call(cs_call), .cs_ret(cs_ret),
        .cs_target_pc(cs_target_pc), .cs_pc_cur(cs_pc_cur), .cs_clr_err(cs_clr_err),
        .cs_busy(cs_busy), .cs_done(cs_done), .cs_pc_load(cs_pc_load), .cs_pc_next(cs_pc_next),
        .rf_stack_push(rf_stack_push), .rf_stack_pop(rf_stack_pop),
        .rf_stack_pointer(rf_stack_pointer), .cs_depth(cs_depth),
        .cs_overflow(cs_overflow), .cs_underflow(cs_underflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4+2*W:0] ctl_exp(input logic [4:0] f, input int ptr, input int dep);
        return {f, W'(ptr), W'(dep)};
    endfunction

    task automatic sb_check(input string name);
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: done with empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            if (cs_pc_next !== e.pc || cs_depth !== e.depth) begin
                miscompares++;
                $display("FAIL %s: pc_next=%0d depth=%0d, expected pc_next=%0d depth=%0d", name, cs_pc_next, cs_depth, e.pc, e.depth);
            end
        end
    endtask

    task automatic do_call(input logic [W-1:0] pc, input logic [W-1:0] tgt, input logic with_ret);
        cs_call = 1'b1; cs_ret = with_ret; cs_pc_cur = pc; cs_target_pc = tgt;
        sb.push_back({tgt, W'(m_sp + 1)});
        step();
        cs_call = 1'b0; cs_ret = 1'b0;
        vectors++;
        if (ctl !== ctl_exp(5'b10010, m_sp + 1, m_sp)) begin
            miscompares++; $display("FAIL call_push: ctl=%b expected %b", ctl, ctl_exp(5'b10010, m_sp + 1, m_sp));
        end
        m_lifo[m_sp + 1] = pc + 1'b1;
        m_sp++;
        step();
        vectors++;
        if (ctl !== ctl_exp(5'b11100, m_sp, m_sp)) begin
            miscompares++; $display("FAIL call_done: ctl=%b expected %b", ctl, ctl_exp(5'b11100, m_sp, m_sp));
        end
        if (cs_done) sb_check("call_result");
        step();
        vectors++;
        if (ctl !== ctl_exp(5'b00000, m_sp, m_sp)) begin
            miscompares++; $display("FAIL call_idle: ctl=%b expected %b", ctl, ctl_exp(5'b00000, m_sp, m_sp));
        end
    endtask

    task automatic do_ret(input logic noise);
        cs_ret = 1'b1;
        sb.push_back({m_lifo[m_sp], W'(m_sp - 1)});
        step();
        cs_ret = 1'b0; cs_call = noise;
        vectors++;
        if (ctl !== ctl_exp(5'b10000, m_sp, m_sp)) begin
            miscompares++; $display("FAIL ret_pop_rd: ctl=%b expected %b", ctl, ctl_exp(5'b10000, m_sp, m_sp));
        end
        step();
        vectors++;
        if (ctl !== ctl_exp(5'b10001, m_sp, m_sp)) begin
            miscompares++; $display("FAIL ret_pop: ctl=%b expected %b", ctl, ctl_exp(5'b10001, m_sp, m_sp));
        end
        m_sp--;
        step();
        cs_call = 1'b0;
        vectors++;
        if (ctl !== ctl_exp(5'b11100, m_sp, m_sp)) begin
            miscompares++; $display("FAIL ret_done: ctl=%b expected %b", ctl, ctl_exp(5'b11100, m_sp, m_sp));
        end
        if (cs_done) sb_check("ret_result");
        step();
        vectors++;
        if (ctl !== ctl_exp(5'b00000, m_sp, m_sp)) begin
            miscompares++; $display("FAIL ret_idle: ctl=%b expected %b", ctl, ctl_exp(5'b00000, m_sp, m_sp));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({ctl, cs_pc_next, cs_overflow, cs_underflow} !== '0) begin
            miscompares++; $display("FAIL reset_state: outputs=%b expected all 0", {ctl, cs_pc_next, cs_overflow, cs_underflow});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_call_ret();
        do_call(5'd3, 5'd12, 1'b0);
        do_ret(1'b0);
    endtask

    task automatic test_nesting();
        for (int i = 0; i < D; i++) do_call(W'(i * 9 + 4), W'(i * 5 + 1), 1'b0);
        cs_call = 1'b1; cs_pc_cur = 5'd7; cs_target_pc = 5'd9;
        step();
        cs_call = 1'b0;
        vectors++;
        if (ctl !== ctl_exp(5'b00000, D, D) || cs_overflow !== 1'b1) begin
            miscompares++; $display("FAIL overflow: ctl=%b ovf=%b expected ctl=%b ovf=1", ctl, cs_overflow, ctl_exp(5'b00000, D, D));
        end
        step();
        vectors++;
        if (ctl !== ctl_exp(5'b00000, D, D)) begin
            miscompares++; $display("FAIL overflow_hold: ctl=%b expected %b", ctl, ctl_exp(5'b00000, D, D));
        end
        for (int i = 0; i < D; i++) do_ret(i[0]);
    endtask

    task automatic test_underflow();
        cs_ret = 1'b1;
        step();
        cs_ret = 1'b0;
        vectors++;
        if (ctl !== ctl_exp(5'b00000, 0, 0) || cs_underflow !== 1'b1) begin
            miscompares++; $display("FAIL underflow: ctl=%b unf=%b expected ctl=0 unf=1", ctl, cs_underflow);
        end
        cs_ret = 1'b1; cs_clr_err = 1'b1;
        step();
        cs_ret = 1'b0;
        vectors++;
        if (cs_underflow !== 1'b1 || cs_overflow !== 1'b0) begin
            miscompares++; $display("FAIL clr_vs_new_err: unf=%b ovf=%b expected unf=1 ovf=0", cs_underflow, cs_overflow);
        end
        step();
        cs_clr_err = 1'b0;
        vectors++;
        if (cs_underflow !== 1'b0 || ctl !== '0) begin
            miscompares++; $display("FAIL clr_err: unf=%b ctl=%b expected unf=0 ctl=0", cs_underflow, ctl);
        end
    endtask

    task automatic test_back_to_back();
        cs_call = 1'b1; cs_pc_cur = 5'd10; cs_target_pc = 5'd20;
        sb.push_back({5'd20, 5'd1});
        step();
        vectors++;
        if (ctl !== ctl_exp(5'b10010, 1, 0)) begin
            miscompares++; $display("FAIL hold_push1: ctl=%b expected %b", ctl, ctl_exp(5'b10010, 1, 0));
        end
        m_lifo[1] = 5'd11; m_sp = 1;
        step();
        if (cs_done) sb_check("hold_result1");
        step();
        vectors++;
        if (ctl !== ctl_exp(5'b00000, 1, 1)) begin
            miscompares++; $display("FAIL hold_idle: ctl=%b expected %b", ctl, ctl_exp(5'b00000, 1, 1));
        end
        cs_pc_cur = 5'd13; cs_target_pc = 5'd22;
        sb.push_back({5'd22, 5'd2});
        step();
        cs_call = 1'b0;
        vectors++;
        if (ctl !== ctl_exp(5'b10010, 2, 1)) begin
            miscompares++; $display("FAIL hold_push2: ctl=%b expected %b", ctl, ctl_exp(5'b10010, 2, 1));
        end
        m_lifo[2] = 5'd14; m_sp = 2;
        step();
        if (cs_done) sb_check("hold_result2");
        step();
        do_ret(1'b0);
        do_call(5'd30, 5'd2, 1'b0);
        do_call(5'd17, 5'd6, 1'b1);
    endtask

    task automatic test_reset_mid();
        cs_call = 1'b1; cs_pc_cur = 5'd1; cs_target_pc = 5'd8;
        step();
        cs_call = 1'b0;
        vectors++;
        if (rf_stack_push !== 1'b1) begin
            miscompares++; $display("FAIL mid_push: push=%b expected 1", rf_stack_push);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({ctl, cs_pc_next, cs_overflow, cs_underflow} !== '0) begin
            miscompares++; $display("FAIL mid_reset: outputs=%b expected all 0", {ctl, cs_pc_next, cs_overflow, cs_underflow});
        end
        #4 rst_n = 1'b1;
        sb.delete();
        m_sp = 0;
        step();
        vectors++;
        if (ctl !== '0) begin
            miscompares++; $display("FAIL post_reset: ctl=%b expected 0", ctl);
        end
        do_call(5'd5, 5'd9, 1'b0);
        do_ret(1'b0);
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_nesting();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
